// File: rtl/rr_multi_producer_fifo_if.sv
// Producer/consumer bundle for the round-robin multi-producer FIFO.
// The FIFO itself sits on the slave side; the producers and consumer sit on the master side.
interface rr_multi_producer_fifo_if #(
    parameter int K = 4,
    parameter int N = 4,
    parameter int C = 3
);
    localparam int CW  = $clog2(C);
    localparam int DCW = $clog2(N) + 1;

    logic [C-1:0]   write;
    logic [C*K-1:0] din;
    logic [C-1:0]   grant;
    logic           read;
    logic [K-1:0]   dout;
    logic [CW-1:0]  dout_ch;
    logic           full;
    logic           empty;
    logic           almost_full;
    logic           almost_empty;
    logic           underflow;
    logic [DCW-1:0] D;

    modport master (
        output write, din, read,
        input  grant, dout, dout_ch, full, empty, almost_full, almost_empty, underflow, D
    );

    modport slave (
        input  write, din, read,
        output grant, dout, dout_ch, full, empty, almost_full, almost_empty, underflow, D
    );
endinterface

// File: rtl/rr_multi_producer_fifo.sv
// C producer channels share one FWFT FIFO through a round-robin arbiter.
// Each entry is tagged with the channel it came from.
module rr_multi_producer_fifo #(
    parameter int K  = 4,
    parameter int N  = 4,
    parameter int C  = 3,
    parameter int AF = 3,
    parameter int AE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    rr_multi_producer_fifo_if.slave bus
);
    localparam int CW  = $clog2(C);
    localparam int AW  = $clog2(N);
    localparam int DCW = AW + 1;

    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [DCW-1:0]  count_reg;
    logic [CW-1:0]   rr_last_reg;
    logic            underflow_reg;
    logic [CW+K-1:0] mem [N];

    logic [CW-1:0]   pick_idx;
    logic            pick_valid;
    logic [CW-1:0]   cand_idx;
    logic [K-1:0]    pick_din;
    logic [C-1:0]    grant_vec;
    logic            grant_en;
    logic            do_pop;
    logic            full;
    logic            empty;
    logic [CW+K-1:0] head;

    assign full  = (count_reg == DCW'(N));
    assign empty = (count_reg == '0);

    // Search upward from the channel after the last winner, wrapping modulo C.
    always_comb begin
        pick_idx   = '0;
        pick_valid = 1'b0;
        cand_idx   = '0;
        for (int off = 1; off <= C; off++) begin
            cand_idx = CW'((int'(rr_last_reg) + off) % C);
            if (!pick_valid && bus.write[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        pick_din = '0;
        for (int i = 0; i < C; i++) begin
            if (pick_idx == CW'(i)) begin
                pick_din = bus.din[i*K +: K];
            end
        end
    end

    // Reset also masks the grant so nothing is written while rst is low.
    assign grant_en = rst && !full && pick_valid;
    assign do_pop   = rst && bus.read && !empty;

    generate
        for (genvar gi = 0; gi < C; gi++) begin : g_grant
            assign grant_vec[gi] = grant_en && (pick_idx == CW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (grant_en) begin
            mem[wr_ptr_reg] <= {pick_idx, pick_din};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            rr_last_reg   <= CW'(C - 1);
            underflow_reg <= 1'b0;
        end else begin
            if (grant_en) begin
                wr_ptr_reg  <= wr_ptr_reg + 1'b1;
                rr_last_reg <= pick_idx;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (grant_en && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (do_pop && !grant_en) begin
                count_reg <= count_reg - 1'b1;
            end
            if (bus.read && empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign head             = mem[rd_ptr_reg];
    assign bus.grant        = grant_vec;
    assign bus.dout         = head[K-1:0];
    assign bus.dout_ch      = head[CW+K-1:K];
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_reg >= DCW'(AF));
    assign bus.almost_empty = (count_reg <= DCW'(AE));
    assign bus.underflow    = underflow_reg;
    assign bus.D            = count_reg;
endmodule

// File: tb/tb_rr_multi_producer_fifo.sv
// Directed bench for rr_multi_producer_fifo with C=3, K=4, N=4, AF=3, AE=1.
// One vector per clock cycle; expectations describe the state before that cycle's edge.
module tb_rr_multi_producer_fifo;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rr_multi_producer_fifo_if #(.K(4), .N(4), .C(3)) bus ();

    rr_multi_producer_fifo #(.K(4), .N(4), .C(3), .AF(3), .AE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [2:0] wr;
        logic       rd;
        logic [2:0] gnt;
        logic [2:0] d;
        logic       uf;
        logic       chk;
        logic [1:0] ch;
        logic [3:0] dat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int r, int wr, int rd, int gnt, int d, int uf, int chk, int ch, int dat);
        vec_t v;
        v.rst = 1'(r);   v.wr = 3'(wr); v.rd  = 1'(rd);  v.gnt = 3'(gnt);
        v.d   = 3'(d);   v.uf = 1'(uf); v.chk = 1'(chk); v.ch  = 2'(ch);
        v.dat = 4'(dat);
        return v;
    endfunction

    task automatic check(string nm, int idx, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec%0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic check_flags(int idx, int d);
        check("D",            idx, 8'(bus.D),            8'(d));
        check("empty",        idx, 8'(bus.empty),        8'(d == 0));
        check("full",         idx, 8'(bus.full),         8'(d == 4));
        check("almost_full",  idx, 8'(bus.almost_full),  8'(d >= 3));
        check("almost_empty", idx, 8'(bus.almost_empty), 8'(d <= 1));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        bus.write = 3'b111;
        bus.read  = 1'b0;
        bus.din   = {4'd3, 4'd2, 4'd1};

        //          rst wr     rd gnt    D  uf chk ch dat
        vecs.push_back(mk(0, 3'b111, 0, 3'b000, 0, 0, 0, 0, 0)); // held in reset
        vecs.push_back(mk(0, 3'b111, 0, 3'b000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b111, 0, 3'b001, 0, 0, 0, 0, 0)); // fill, rotating grants
        vecs.push_back(mk(1, 3'b111, 0, 3'b010, 1, 0, 1, 0, 1));
        vecs.push_back(mk(1, 3'b111, 0, 3'b100, 2, 0, 1, 0, 1));
        vecs.push_back(mk(1, 3'b111, 0, 3'b001, 3, 0, 1, 0, 1));
        vecs.push_back(mk(1, 3'b111, 0, 3'b000, 4, 0, 1, 0, 1)); // full blocks grant
        vecs.push_back(mk(1, 3'b000, 1, 3'b000, 4, 0, 1, 0, 1)); // drain
        vecs.push_back(mk(1, 3'b000, 1, 3'b000, 3, 0, 1, 1, 2));
        vecs.push_back(mk(1, 3'b000, 1, 3'b000, 2, 0, 1, 2, 3));
        vecs.push_back(mk(1, 3'b000, 1, 3'b000, 1, 0, 1, 0, 1));
        vecs.push_back(mk(1, 3'b100, 0, 3'b100, 0, 0, 0, 0, 0)); // rotation check
        vecs.push_back(mk(1, 3'b101, 0, 3'b001, 1, 0, 1, 2, 3));
        vecs.push_back(mk(1, 3'b101, 0, 3'b100, 2, 0, 1, 2, 3));
        vecs.push_back(mk(1, 3'b001, 0, 3'b001, 3, 0, 1, 2, 3));
        vecs.push_back(mk(1, 3'b010, 1, 3'b000, 4, 0, 1, 2, 3)); // full + read: pop only
        vecs.push_back(mk(1, 3'b010, 1, 3'b010, 3, 0, 1, 0, 1)); // write + pop together
        vecs.push_back(mk(1, 3'b000, 1, 3'b000, 3, 0, 1, 2, 3));
        vecs.push_back(mk(1, 3'b000, 1, 3'b000, 2, 0, 1, 0, 1));
        vecs.push_back(mk(1, 3'b000, 1, 3'b000, 1, 0, 1, 1, 2));
        vecs.push_back(mk(1, 3'b000, 1, 3'b000, 0, 0, 0, 0, 0)); // read while empty
        vecs.push_back(mk(1, 3'b000, 0, 3'b000, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b010, 0, 3'b010, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b000, 1, 3'b000, 1, 1, 1, 1, 2));
        vecs.push_back(mk(0, 3'b000, 0, 3'b000, 0, 1, 0, 0, 0)); // reset clears underflow
        vecs.push_back(mk(1, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b001, 0, 3'b001, 0, 0, 0, 0, 0)); // fill to 3
        vecs.push_back(mk(1, 3'b001, 0, 3'b001, 1, 0, 1, 0, 1));
        vecs.push_back(mk(1, 3'b001, 0, 3'b001, 2, 0, 1, 0, 1));
        vecs.push_back(mk(0, 3'b111, 0, 3'b000, 3, 0, 1, 0, 1)); // mid-stream reset
        vecs.push_back(mk(1, 3'b110, 0, 3'b010, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b000, 0, 3'b000, 1, 0, 1, 1, 2));

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst       = vecs[i].rst;
            bus.write = vecs[i].wr;
            bus.read  = vecs[i].rd;
            @(negedge clk);
            $display("vec %0d: rst=%b write=%b read=%b grant=%b D=%0d uf=%b head=(%0d,%0d)",
                     i, rst, bus.write, bus.read, bus.grant, bus.D, bus.underflow, bus.dout_ch, bus.dout);
            check("grant",     i, 8'(bus.grant),     8'(vecs[i].gnt));
            check("underflow", i, 8'(bus.underflow), 8'(vecs[i].uf));
            check_flags(i, int'(vecs[i].d));
            if (vecs[i].chk) begin
                check("dout_ch", i, 8'(bus.dout_ch), 8'(vecs[i].ch));
                check("dout",    i, 8'(bus.dout),    8'(vecs[i].dat));
            end
            @(posedge clk);
            #1;
        end

        // Streaming: all channels request and the consumer pops every cycle; D stays at 1.
        bus.write = 3'b111;
        bus.read  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            $display("stream %0d: grant=%b D=%0d head=(%0d,%0d)", k, bus.grant, bus.D, bus.dout_ch, bus.dout);
            check("stream_grant", 100 + k, 8'(bus.grant),   8'(1 << ((2 + k) % 3)));
            check("stream_ch",    100 + k, 8'(bus.dout_ch), 8'((1 + k) % 3));
            check("stream_dout",  100 + k, 8'(bus.dout),    8'((1 + k) % 3 + 1));
            check("stream_D",     100 + k, 8'(bus.D),       8'd1);
            @(posedge clk);
            #1;
        end

        // Fill from ch0 only until full, within a bounded number of cycles.
        bus.write = 3'b001;
        bus.read  = 1'b0;
        begin
            int waited;
            waited = 0;
            @(negedge clk);
            while (!bus.full && waited < 10) begin
                @(posedge clk);
                #1;
                @(negedge clk);
                waited++;
            end
            $display("fill: full=%b after %0d cycles, D=%0d grant=%b", bus.full, waited, bus.D, bus.grant);
            check("fill_cycles", 200, 8'(waited),      8'd3);
            check("fill_D",      200, 8'(bus.D),       8'd4);
            check("fill_grant",  200, 8'(bus.grant),   8'd0);
            check("fill_head",   200, 8'(bus.dout_ch), 8'd2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
